// File: rtl/bram_port_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : bram_port_rr_arbiter_if
// Brief  : Request/response and BRAM-port bundle for bram_port_rr_arbiter.
//          "master" is the outside world (requesters plus the BRAM read data),
//          "slave" is the arbiter itself.
// Rev    : 1.0 - initial release
// ============================================================================
interface bram_port_rr_arbiter_if #(
  parameter int REQ_N     = 2,
  parameter int MEM_WIDTH = 32
);
  logic [REQ_N-1:0]               req_valid;
  logic [REQ_N-1:0]               req_ready;
  logic [REQ_N-1:0]               req_lock;
  logic [REQ_N*MEM_WIDTH/8-1:0]   req_wen;
  logic [REQ_N*32-1:0]            req_addr;
  logic [REQ_N*MEM_WIDTH-1:0]     req_wdata;
  logic [REQ_N-1:0]               resp_valid;
  logic [MEM_WIDTH-1:0]           resp_rdata;
  logic                           bram_en;
  logic [MEM_WIDTH/8-1:0]         bram_we;
  logic [31:0]                    bram_addr;
  logic [MEM_WIDTH-1:0]           bram_din;
  logic [MEM_WIDTH-1:0]           bram_dout;

  modport master (
    output req_valid, req_lock, req_wen, req_addr, req_wdata, bram_dout,
    input  req_ready, resp_valid, resp_rdata, bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  req_valid, req_lock, req_wen, req_addr, req_wdata, bram_dout,
    output req_ready, resp_valid, resp_rdata, bram_en, bram_we, bram_addr, bram_din
  );
endinterface
`default_nettype wire

// File: rtl/bram_port_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bram_port_rr_arbiter
// Brief  : Round-robin arbiter sharing one BRAM port among REQ_N requesters,
//          with optional grant lock and read-response tagging.
// Rev    : 1.0 - initial release
// ============================================================================
module bram_port_rr_arbiter #(
  parameter int REQ_N        = 2,
  parameter int MEM_WIDTH    = 32,
  parameter int READ_LATENCY = 1,
  parameter int SIM_DELAY    = 1
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  bram_port_rr_arbiter_if.slave   bus
);

  localparam int c_BE_W = MEM_WIDTH / 8;
  localparam int c_ID_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  // Registers carry no delay in this implementation, so SIM_DELAY only takes
  // part in the legality check below.
  if (REQ_N < 1 || REQ_N > 8 || (MEM_WIDTH % 8) != 0 || MEM_WIDTH < 8 ||
      READ_LATENCY < 1 || SIM_DELAY < 0) begin : g_param_check
    $error("bram_port_rr_arbiter: illegal parameter combination");
  end

  logic [c_ID_W-1:0] r_rr_ptr;
  logic              r_lock_vld;
  logic [c_ID_W-1:0] r_lock_owner;
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [c_ID_W-1:0]       r_pipe_id [READ_LATENCY];

  logic              w_any;
  logic              w_found;
  int                w_idx;
  logic [c_ID_W-1:0] w_rr_grant;
  logic              w_lock_hit;
  logic [c_ID_W-1:0] w_grant;
  logic [c_ID_W-1:0] w_grant_inc;
  logic [c_ID_W-1:0] w_owner_inc;
  logic [c_BE_W-1:0] w_wen_sel;
  logic              w_is_read;

  // Rotating priority search starting at the round-robin pointer, with the
  // lock owner taking precedence whenever it is still requesting.
  always_comb begin
    w_any      = |bus.req_valid;
    w_found    = 1'b0;
    w_idx      = 0;
    w_rr_grant = r_rr_ptr;
    for (int k = 0; k < REQ_N; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= REQ_N) w_idx = w_idx - REQ_N;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found    = 1'b1;
        w_rr_grant = c_ID_W'(w_idx);
      end
    end
    w_lock_hit = r_lock_vld && bus.req_valid[r_lock_owner];
    w_grant    = w_lock_hit ? r_lock_owner : w_rr_grant;
  end

  // Modulo-REQ_N successors of the grant and of the lock owner.
  always_comb begin
    w_grant_inc = (w_grant == c_ID_W'(REQ_N - 1)) ? '0 : w_grant + 1'b1;
    w_owner_inc = (r_lock_owner == c_ID_W'(REQ_N - 1)) ? '0 : r_lock_owner + 1'b1;
  end

  // Granted slice onto the BRAM port; ready is purely a function of requests.
  always_comb begin
    w_wen_sel      = bus.req_wen[int'(w_grant)*c_BE_W +: c_BE_W];
    w_is_read      = (w_wen_sel == '0);
    bus.req_ready  = w_any ? (REQ_N'(1) << w_grant) : '0;
    bus.bram_en    = w_any;
    bus.bram_we    = w_any ? w_wen_sel : '0;
    bus.bram_addr  = bus.req_addr[int'(w_grant)*32 +: 32];
    bus.bram_din   = bus.req_wdata[int'(w_grant)*MEM_WIDTH +: MEM_WIDTH];
  end

  // Pointer and lock bookkeeping. A vanished lock owner releases the lock
  // even without a transfer; otherwise state only moves on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_lock_vld   <= 1'b0;
      r_lock_owner <= '0;
    end else if (r_lock_vld && !bus.req_valid[r_lock_owner]) begin
      r_rr_ptr     <= w_owner_inc;
      r_lock_vld   <= w_any && bus.req_lock[w_grant];
      r_lock_owner <= w_grant;
    end else if (w_any) begin
      if (bus.req_lock[w_grant]) begin
        r_lock_vld   <= 1'b1;
        r_lock_owner <= w_grant;
      end else begin
        r_lock_vld   <= 1'b0;
        r_rr_ptr     <= w_grant_inc;
      end
    end
  end

  // Response tag pipeline, aligned with the BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int s = 0; s < READ_LATENCY; s++) r_pipe_id[s] <= '0;
    end else begin
      r_pipe_vld[0] <= w_any && w_is_read;
      r_pipe_id[0]  <= w_grant;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_id[s]  <= r_pipe_id[s-1];
      end
    end
  end

  // Decode the tag leaving the pipeline; read data passes straight through.
  always_comb begin
    bus.resp_valid = r_pipe_vld[READ_LATENCY-1] ? (REQ_N'(1) << r_pipe_id[READ_LATENCY-1]) : '0;
    bus.resp_rdata = bus.bram_dout;
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bram_port_rr_arbiter
// Brief  : Directed testbench; one arbiter with READ_LATENCY=1 (a) and one
//          with READ_LATENCY=2 (b), each in front of a small BRAM model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bram_port_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  bram_port_rr_arbiter_if #(.REQ_N(2), .MEM_WIDTH(32)) ifa ();
  bram_port_rr_arbiter_if #(.REQ_N(2), .MEM_WIDTH(32)) ifb ();

  bram_port_rr_arbiter #(.REQ_N(2), .MEM_WIDTH(32), .READ_LATENCY(1), .SIM_DELAY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  bram_port_rr_arbiter #(.REQ_N(2), .MEM_WIDTH(32), .READ_LATENCY(2), .SIM_DELAY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models (no_change mode: a write leaves the output unchanged)
  logic [31:0] mema [256];
  logic [31:0] memb [256];
  logic [31:0] douta, doutb1, doutb2;

  function automatic logic [31:0] f_init(int a);
    return 32'h5A00_0000 | 32'(a);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mema[i] = f_init(i);
      memb[i] = f_init(i);
    end
  end

  always @(posedge clk) begin
    if (ifa.bram_en) begin
      if (ifa.bram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (ifa.bram_we[b]) mema[ifa.bram_addr[7:0]][8*b +: 8] <= ifa.bram_din[8*b +: 8];
      end else begin
        douta <= mema[ifa.bram_addr[7:0]];
      end
    end
  end

  always @(posedge clk) begin
    if (ifb.bram_en) begin
      if (ifb.bram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (ifb.bram_we[b]) memb[ifb.bram_addr[7:0]][8*b +: 8] <= ifb.bram_din[8*b +: 8];
      end else begin
        doutb1 <= memb[ifb.bram_addr[7:0]];
      end
    end
    doutb2 <= doutb1;
  end

  assign ifa.bram_dout = douta;
  assign ifb.bram_dout = doutb2;

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", ifa.req_ready); end
    n_vec++; if (ifa.resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_resp_a: got %b want 00", ifa.resp_valid); end
    n_vec++; if (ifb.resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_resp_b: got %b want 00", ifb.resp_valid); end
    n_vec++; if (ifa.bram_en !== 1'b0 || ifa.bram_we !== 4'h0) begin
      n_err++; $display("FAIL reset_bram: got en=%b we=%h want en=0 we=0", ifa.bram_en, ifa.bram_we);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rr_reads();
    logic [1:0]  exp_rdy;
    logic [1:0]  prev_rdy;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    ifa.req_valid = 2'b11;
    ifa.req_lock  = 2'b00;
    ifa.req_wen   = '0;
    ifa.req_addr  = {32'h20, 32'h10};
    prev_rdy = 2'b00;
    for (int k = 0; k < 6; k++) begin
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'h10 : 32'h20;
      @(negedge clk);
      n_vec++; if (ifa.req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", k, ifa.req_ready, exp_rdy); end
      n_vec++; if (ifa.bram_addr !== exp_addr) begin n_err++; $display("FAIL rr_addr[%0d]: got %h want %h", k, ifa.bram_addr, exp_addr); end
      n_vec++; if (ifa.resp_valid !== prev_rdy) begin n_err++; $display("FAIL rr_resp[%0d]: got %b want %b", k, ifa.resp_valid, prev_rdy); end
      if (prev_rdy != 2'b00) begin
        exp_data = prev_rdy[0] ? f_init(16) : f_init(32);
        n_vec++; if (ifa.resp_rdata !== exp_data) begin n_err++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, ifa.resp_rdata, exp_data); end
      end
      prev_rdy = exp_rdy;
      @(posedge clk); #1;
    end
    ifa.req_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (ifa.resp_valid !== 2'b10) begin n_err++; $display("FAIL rr_last_resp: got %b want 10", ifa.resp_valid); end
    n_vec++; if (ifa.resp_rdata !== f_init(32)) begin n_err++; $display("FAIL rr_last_rdata: got %h want %h", ifa.resp_rdata, f_init(32)); end
    n_vec++; if (ifa.bram_en !== 1'b0 || ifa.bram_we !== 4'h0) begin
      n_err++; $display("FAIL idle_bram: got en=%b we=%h want en=0 we=0", ifa.bram_en, ifa.bram_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_then_read();
    ifa.req_valid = 2'b01;
    ifa.req_wen   = {4'h0, 4'hF};
    ifa.req_addr  = {32'h0, 32'h4};
    ifa.req_wdata = {32'h0, 32'hDEADBEEF};
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready: got %b want 01", ifa.req_ready); end
    n_vec++; if (ifa.bram_we !== 4'hF || ifa.bram_din !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_drive: got we=%h din=%h want we=f din=deadbeef", ifa.bram_we, ifa.bram_din);
    end
    @(posedge clk); #1;
    ifa.req_wen = '0;
    @(negedge clk);
    n_vec++; if (ifa.resp_valid !== 2'b00) begin n_err++; $display("FAIL wr_no_resp: got %b want 00", ifa.resp_valid); end
    n_vec++; if (ifa.bram_we !== 4'h0) begin n_err++; $display("FAIL rd_we: got %h want 0", ifa.bram_we); end
    @(posedge clk); #1;
    ifa.req_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (ifa.resp_valid !== 2'b01) begin n_err++; $display("FAIL wr_rd_resp: got %b want 01", ifa.resp_valid); end
    n_vec++; if (ifa.resp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_data: got %h want deadbeef", ifa.resp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    // single r0 transfer puts the pointer on requester 1
    ifa.req_valid = 2'b01;
    ifa.req_addr  = {32'h20, 32'h8};
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b01) begin n_err++; $display("FAIL lock_pre: got %b want 01", ifa.req_ready); end
    @(posedge clk); #1;
    ifa.req_valid = 2'b11;
    ifa.req_lock  = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (ifa.req_ready !== 2'b10) begin n_err++; $display("FAIL lock_hold[%0d]: got %b want 10", k, ifa.req_ready); end
      @(posedge clk); #1;
    end
    ifa.req_lock = 2'b00;
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b10) begin n_err++; $display("FAIL lock_release_xfer: got %b want 10", ifa.req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b01) begin n_err++; $display("FAIL lock_after: got %b want 01", ifa.req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_lock_owner_drops();
    // pointer on 1: requester 1 wins by round robin and takes the lock
    ifa.req_valid = 2'b11;
    ifa.req_lock  = 2'b10;
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b10) begin n_err++; $display("FAIL drop_take: got %b want 10", ifa.req_ready); end
    @(posedge clk); #1;
    // owner vanishes: lock released, pointer goes to owner+1 = 0
    ifa.req_valid = 2'b01;
    ifa.req_lock  = 2'b00;
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b01) begin n_err++; $display("FAIL drop_other: got %b want 01", ifa.req_ready); end
    @(posedge clk); #1;
    ifa.req_valid = 2'b11;
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b01) begin n_err++; $display("FAIL drop_after: got %b want 01", ifa.req_ready); end
    @(posedge clk); #1;
    ifa.req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_latency2();
    logic [1:0]  exp_rdy [3];
    logic [31:0] exp_data [3];
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01;
    exp_data[0] = f_init(1); exp_data[1] = f_init(2); exp_data[2] = f_init(3);
    ifb.req_lock = 2'b00;
    ifb.req_wen  = '0;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin ifb.req_valid = 2'b01; ifb.req_addr = {32'h0, 32'h1}; end
        1: begin ifb.req_valid = 2'b10; ifb.req_addr = {32'h2, 32'h0}; end
        2: begin ifb.req_valid = 2'b01; ifb.req_addr = {32'h0, 32'h3}; end
        default: ifb.req_valid = 2'b00;
      endcase
      @(negedge clk);
      if (k < 3) begin
        n_vec++; if (ifb.req_ready !== exp_rdy[k]) begin n_err++; $display("FAIL l2_ready[%0d]: got %b want %b", k, ifb.req_ready, exp_rdy[k]); end
      end
      if (k >= 2 && k < 5) begin
        n_vec++; if (ifb.resp_valid !== exp_rdy[k-2]) begin n_err++; $display("FAIL l2_resp[%0d]: got %b want %b", k, ifb.resp_valid, exp_rdy[k-2]); end
        n_vec++; if (ifb.resp_rdata !== exp_data[k-2]) begin n_err++; $display("FAIL l2_rdata[%0d]: got %h want %h", k, ifb.resp_rdata, exp_data[k-2]); end
      end else begin
        n_vec++; if (ifb.resp_valid !== 2'b00) begin n_err++; $display("FAIL l2_quiet[%0d]: got %b want 00", k, ifb.resp_valid); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_inflight();
    ifa.req_valid = 2'b11; ifa.req_wen = '0; ifa.req_lock = 2'b00;
    ifa.req_addr  = {32'h40, 32'h30};
    ifb.req_valid = 2'b11; ifb.req_wen = '0; ifb.req_lock = 2'b00;
    ifb.req_addr  = {32'h40, 32'h30};
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifa.req_valid = 2'b00;
    ifb.req_valid = 2'b00;
    n_vec++; if (ifa.resp_valid !== 2'b01) begin n_err++; $display("FAIL rst_pre_a: got %b want 01", ifa.resp_valid); end
    n_vec++; if (ifb.resp_valid !== 2'b10) begin n_err++; $display("FAIL rst_pre_b: got %b want 10", ifb.resp_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (ifa.resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_async_a: got %b want 00", ifa.resp_valid); end
    n_vec++; if (ifb.resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_async_b: got %b want 00", ifb.resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (ifa.resp_valid !== 2'b00 || ifb.resp_valid !== 2'b00) begin
      n_err++; $display("FAIL rst_stale: got a=%b b=%b want 00 00", ifa.resp_valid, ifb.resp_valid);
    end
    @(posedge clk); #1;
    ifa.req_valid = 2'b11;
    @(negedge clk);
    n_vec++; if (ifa.req_ready !== 2'b01) begin n_err++; $display("FAIL rst_first_grant: got %b want 01", ifa.req_ready); end
    @(posedge clk); #1;
    ifa.req_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (ifa.resp_valid !== 2'b01) begin n_err++; $display("FAIL rst_post_resp: got %b want 01", ifa.resp_valid); end
    n_vec++; if (ifa.resp_rdata !== f_init(48)) begin n_err++; $display("FAIL rst_post_data: got %h want %h", ifa.resp_rdata, f_init(48)); end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifa.req_valid = '0; ifa.req_lock = '0; ifa.req_wen = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = '0; ifb.req_lock = '0; ifb.req_wen = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rr_reads();
    test_write_then_read();
    test_lock();
    test_lock_owner_drops();
    test_latency2();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
